// File: rtl/wait_state_memory_if.sv
// Control side of the wait-state memory bus. The tri-state data lines stay on the
// module port so that each bus has a single resolved net.
interface wait_state_memory_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  ce_n;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_n;
    logic                  wr_n;
    logic                  buswait_n;
    logic                  busrq_n;
    logic                  busack_n;

    modport master (output ce_n, addr, rd_n, wr_n, busack_n,
                    input  buswait_n, busrq_n);
    modport slave  (input  ce_n, addr, rd_n, wr_n, busack_n,
                    output buswait_n, busrq_n);
endinterface

// File: rtl/wait_state_memory.sv
// Small register-file memory on a Z80-style bus. It inserts a fixed number of wait
// states per access and commits exactly one write per strobe assertion.
module wait_state_memory #(
    parameter logic [3:0] ID         = 4'h0,
    parameter int         DATA_WIDTH = 8,
    parameter int         ADDR_WIDTH = 16,
    parameter int         DEPTH      = 4,
    parameter int         RD_WAIT    = 0,
    parameter int         WR_WAIT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    wait_state_memory_if.slave    bus,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0] idx;
    logic          present;
    logic          is_wr;
    logic          rd_drive;
    logic [3:0]    wait_cnt;
    logic          unused_ok;

    // Upper address bits alias onto the same words.
    assign idx      = bus.addr[IW-1:0];
    assign is_wr    = !bus.wr_n;
    assign present  = !bus.ce_n && (!bus.rd_n || !bus.wr_n);
    assign rd_drive = !bus.ce_n && !bus.rd_n && bus.wr_n;
    assign wait_cnt = is_wr ? 4'(WR_WAIT) : 4'(RD_WAIT);

    assign data          = rd_drive ? mem[idx] : {DATA_WIDTH{1'bz}};
    assign bus.buswait_n = !((state == BUSY) && !bus.ce_n);
    assign bus.busrq_n   = 1'b1;
    assign unused_ok     = ^{bus.busack_n, bus.addr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= {ID, (DATA_WIDTH-4)'(i)};
        end else begin
            case (state)
                IDLE: if (present) begin
                    // The write lands on the acceptance edge; later data changes are ignored.
                    if (is_wr) mem[idx] <= data;
                    cnt   <= wait_cnt;
                    state <= (wait_cnt != 4'd0) ? BUSY : HOLD;
                end
                BUSY: begin
                    if (bus.ce_n) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= HOLD;
                    end
                end
                HOLD: if (!present) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench: stimulus pushes expected observations, a negedge monitor pops and compares.
module tb_wait_state_memory;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wait_state_memory_if #(.ADDR_WIDTH(16)) bus_a ();
    wait_state_memory_if #(.ADDR_WIDTH(16)) bus_b ();

    wire  [7:0] data_a;
    wire  [7:0] data_b;
    logic       en_a, en_b;
    logic [7:0] drv_a, drv_b;
    assign data_a = en_a ? drv_a : 8'bz;
    assign data_b = en_b ? drv_b : 8'bz;

    wait_state_memory #(.ID(4'hA), .DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(4),
                        .RD_WAIT(0), .WR_WAIT(2))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a), .data(data_a));

    wait_state_memory #(.ID(4'h5), .DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(4),
                        .RD_WAIT(3), .WR_WAIT(2))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b), .data(data_b));

    // kind: 0 data_a, 1 buswait_n a, 2 data_b, 3 buswait_n b, 4 busrq_n a
    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    exp_t        cur;
    logic [31:0] obs;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            case (cur.kind)
                0:       obs = {24'd0, data_a};
                1:       obs = {31'd0, bus_a.buswait_n};
                2:       obs = {24'd0, data_b};
                3:       obs = {31'd0, bus_b.buswait_n};
                default: obs = {31'd0, bus_a.busrq_n};
            endcase
            tests++;
            if (obs !== cur.val) begin
                failed++;
                $display("FAIL %s: got %h, expected %h at %0t", cur.name, obs, cur.val, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int k, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = k; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic a_set(input logic ce, input logic rd, input logic wr, input logic [15:0] ad);
        bus_a.ce_n = ce; bus_a.rd_n = rd; bus_a.wr_n = wr; bus_a.addr = ad;
    endtask

    task automatic b_set(input logic ce, input logic rd, input logic wr, input logic [15:0] ad);
        bus_b.ce_n = ce; bus_b.rd_n = rd; bus_b.wr_n = wr; bus_b.addr = ad;
    endtask

    initial begin
        reset = 1'b1;
        a_set(1, 1, 1, 0); b_set(1, 1, 1, 0);
        bus_a.busack_n = 1'b1; bus_b.busack_n = 1'b1;
        en_a = 0; en_b = 0; drv_a = 0; drv_b = 0;

        tick(); expect_val(1, 1, "rst_wait_a"); expect_val(4, 1, "rst_busrq_a");
                expect_val(3, 1, "rst_wait_b");
        tick(); reset = 1'b0; expect_val(1, 1, "post_rst_wait_a");
        tick();

        // reset pattern, no read wait states
        for (int i = 0; i < 4; i++) begin
            tick(); a_set(0, 0, 1, 16'(i));
            expect_val(0, 32'hA0 + 32'(i), "init_rd"); expect_val(1, 1, "rd_nowait");
        end
        tick(); a_set(1, 1, 1, 0);

        // write with two wait states
        tick(); a_set(0, 1, 0, 1); en_a = 1; drv_a = 8'h5C; expect_val(1, 1, "wr_accept");
        tick(); expect_val(1, 0, "wr_wait1");
        tick(); expect_val(1, 0, "wr_wait2");
        tick(); expect_val(1, 1, "wr_done");
        tick(); a_set(1, 1, 1, 0); en_a = 0;
        tick(); a_set(0, 0, 1, 1); expect_val(0, 32'h5C, "rd_back_5c");
        tick(); a_set(1, 1, 1, 0);

        // long write strobe with changing data
        for (int k = 0; k < 10; k++) begin
            tick(); a_set(0, 1, 0, 2); en_a = 1; drv_a = 8'h30 + 8'(k);
            if (k == 1 || k == 2) expect_val(1, 0, "hold_wait");
            if (k >= 3) expect_val(1, 1, "hold_nowait");
        end
        tick(); a_set(1, 1, 1, 0); en_a = 0;
        tick(); a_set(0, 0, 1, 2); expect_val(0, 32'h30, "one_commit");
        tick(); a_set(1, 1, 1, 0);

        // address aliasing
        tick(); a_set(0, 1, 0, 16'h0006); en_a = 1; drv_a = 8'h77;
        tick(); tick(); tick();
        tick(); a_set(1, 1, 1, 0); en_a = 0;
        tick(); a_set(0, 0, 1, 2); expect_val(0, 32'h77, "alias_rd2");
        tick(); a_set(0, 0, 1, 16'h0006); expect_val(0, 32'h77, "alias_rd6");
        tick(); a_set(1, 1, 1, 0);

        // reset during the busy phase of a write
        tick(); a_set(0, 1, 0, 3); en_a = 1; drv_a = 8'hEE;
        tick(); expect_val(1, 0, "rst_mid_busy"); reset = 1'b1;
        tick(); reset = 1'b0; a_set(1, 1, 1, 0); en_a = 0; expect_val(1, 1, "rst_mid_wait");
        tick(); a_set(0, 0, 1, 3); expect_val(0, 32'hA3, "rst_mid_init");
        tick(); a_set(1, 1, 1, 0);

        // abort a 3-wait read by dropping ce_n, then a full read
        tick(); b_set(0, 0, 1, 1); expect_val(2, 32'h51, "b_rd1"); expect_val(3, 1, "b_accept");
        tick(); expect_val(3, 0, "b_wait1");
        tick(); b_set(1, 1, 1, 1); expect_val(3, 1, "b_abort");
        tick(); b_set(0, 0, 1, 2); expect_val(2, 32'h52, "b_rd2"); expect_val(3, 1, "b_reaccept");
        for (int k = 0; k < 3; k++) begin
            tick(); expect_val(3, 0, "b_rd_wait");
        end
        tick(); expect_val(3, 1, "b_rd_done");
        tick(); b_set(1, 1, 1, 0);
        tick();

        // strobe change while busy keeps the count and the single commit
        tick(); b_set(0, 1, 0, 0); en_b = 1; drv_b = 8'h99; expect_val(3, 1, "chg_accept");
        tick(); b_set(0, 0, 1, 0); en_b = 0; expect_val(3, 0, "chg_wait1");
                expect_val(2, 32'h99, "chg_data");
        tick(); expect_val(3, 0, "chg_wait2");
        tick(); expect_val(3, 1, "chg_done"); expect_val(2, 32'h99, "chg_data_hold");
        tick(); b_set(1, 1, 1, 0);

        @(negedge clk); #1;
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
